// File: rtl/i3c_pkg.sv
// Shared encodings for the I3C pad mode sequencer: bus modes, FSM states and
// the per-state pad control pattern.
package i3c_pkg;

  localparam logic [1:0] I3C_MODE_IDLE = 2'd0;
  localparam logic [1:0] I3C_MODE_OD   = 2'd1;
  localparam logic [1:0] I3C_MODE_PP   = 2'd2;
  localparam logic [1:0] I3C_MODE_BAD  = 2'd3;

  // Stable states share their encoding with the mode they establish.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_OD     = 3'd1;
  localparam logic [2:0] ST_PP     = 3'd2;
  localparam logic [2:0] ST_BREAK  = 3'd3;
  localparam logic [2:0] ST_SETTLE = 3'd4;

  typedef struct packed {
    logic pu_enb;
    logic wkpu_enb;
    logic pp_oe_en;
  } pad_ctrl_t;

  function automatic pad_ctrl_t state_pads(input logic [2:0] st);
    pad_ctrl_t p;
    case (st)
      ST_OD, ST_SETTLE: p = '{pu_enb: 1'b0, wkpu_enb: 1'b1, pp_oe_en: 1'b0};
      ST_PP:            p = '{pu_enb: 1'b1, wkpu_enb: 1'b1, pp_oe_en: 1'b1};
      default:          p = '{pu_enb: 1'b1, wkpu_enb: 1'b0, pp_oe_en: 1'b0};
    endcase
    return p;
  endfunction

  function automatic logic is_stable(input logic [2:0] st);
    return (st == ST_IDLE) || (st == ST_OD) || (st == ST_PP);
  endfunction

endpackage

// File: rtl/i3c_bus_mode_ctrl.sv
// Sequences SB_IO_I3C pull-up and push-pull enables between idle, open-drain
// and push-pull with break-before-make dead time and pull-up settle time.
module i3c_bus_mode_ctrl
  import i3c_pkg::*;
#(
  parameter int DEAD_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int SCL_PULLUP    = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  input  logic [1:0] req_mode,
  output logic       req_ready,
  output logic       done,
  output logic       err,
  output logic [1:0] cur_mode,
  output logic       scl_pu_enb,
  output logic       sda_pu_enb,
  output logic       scl_wkpu_enb,
  output logic       sda_wkpu_enb,
  output logic       pp_oe_en
);

  localparam int MAX_CYCLES = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       tgt_q, tgt_d;
  logic             done_d, err_d;
  pad_ctrl_t        pads_q;

  // Handshake: a request transfers on a rising clk edge with req_valid & req_ready;
  // req_ready is high only in stable states and req_valid is ignored otherwise.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_OD, ST_PP: begin
        if (req_valid) begin
          if (req_mode == I3C_MODE_BAD) begin
            err_d = 1'b1;
          end else if (req_mode == cur_mode) begin
            done_d = 1'b1;
          end else if (cur_mode == I3C_MODE_OD && req_mode == I3C_MODE_IDLE) begin
            // Dropping the strong pull-up never conflicts with a driver.
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (cur_mode == I3C_MODE_IDLE && req_mode == I3C_MODE_OD) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYCLES);
            tgt_d   = req_mode;
          end else begin
            state_d = ST_BREAK;
            cnt_d   = CNT_W'(DEAD_CYCLES);
            tgt_d   = req_mode;
          end
        end
      end
      ST_BREAK: begin
        if (cnt_q == CNT_W'(1)) begin
          if (tgt_q == I3C_MODE_OD) begin
            state_d = ST_SETTLE;
            cnt_d   = CNT_W'(SETTLE_CYCLES);
          end else begin
            state_d = {1'b0, tgt_q};
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_OD;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output is registered from the next state so pads change with the state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      tgt_q     <= I3C_MODE_IDLE;
      done      <= 1'b0;
      err       <= 1'b0;
      req_ready <= 1'b1;
      cur_mode  <= I3C_MODE_IDLE;
      pads_q    <= state_pads(ST_IDLE);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      done      <= done_d;
      err       <= err_d;
      req_ready <= is_stable(state_d);
      pads_q    <= state_pads(state_d);
      if (is_stable(state_d)) begin
        cur_mode <= state_d[1:0];
      end
    end
  end

  assign sda_pu_enb   = pads_q.pu_enb;
  assign sda_wkpu_enb = pads_q.wkpu_enb;
  assign pp_oe_en     = pads_q.pp_oe_en;
  assign scl_pu_enb   = (SCL_PULLUP != 0) ? pads_q.pu_enb   : 1'b1;
  assign scl_wkpu_enb = (SCL_PULLUP != 0) ? pads_q.wkpu_enb : 1'b0;

endmodule
